fetch_target_queue: RTL

- Circular queue of fetch blocks between the branch predictor (BPU) and the IFU.
- Sequences the IFU: presents one fetch block per cycle (start_pc, length, cross-cacheline flag, queue id) and advances only when the IFU accepts it.
- Holds issued blocks until backend commit, so flushes and commit accounting have a single owner.

---
 rtl/fetch_target_queue_pkg.sv | 31 +++
 rtl/fetch_target_queue_ptr_ctrl.sv | 84 ++++++++
 rtl/fetch_target_queue.sv | 92 +++++++++
 3 files changed

// File: rtl/fetch_target_queue_pkg.sv
// Frontend shared definitions for the fetch target queue: sizing constants,
// pointer type, stored entry layout and the FTQ-to-IFU output bundle.
package fetch_target_queue_pkg;

  localparam int FTQ_DEPTH       = 8;
  localparam int FTQ_FETCH_WIDTH = 4;
  localparam int FTQ_ADDR_WIDTH  = 32;
  localparam int CACHELINE_BYTES = FTQ_FETCH_WIDTH * 4;

  localparam int FTQ_PTR_W = $clog2(FTQ_DEPTH) + 1;
  localparam int FTQ_IDX_W = $clog2(FTQ_DEPTH);
  localparam int FTQ_LEN_W = $clog2(FTQ_FETCH_WIDTH) + 1;

  // Queue pointer: low bits index the entry, MSB is the wrap bit.
  typedef logic [FTQ_PTR_W-1:0] ftq_ptr_t;

  typedef struct packed {
    logic [FTQ_ADDR_WIDTH-1:0] start_pc;
    logic [FTQ_LEN_W-1:0]      length;
    logic                      is_cross_cacheline;
  } ftq_entry_t;

  typedef struct packed {
    logic                      valid;
    logic [FTQ_ADDR_WIDTH-1:0] start_pc;
    logic [FTQ_LEN_W-1:0]      length;
    logic                      is_cross_cacheline;
    logic [FTQ_IDX_W-1:0]      id;
  } ftq_to_ifu_t;

endpackage

// File: rtl/fetch_target_queue_ptr_ctrl.sv
// Pointer control for the fetch target queue: write, issue and retire
// pointers, occupancy/full logic, handshake generation and flush handling.
module ftq_ptr_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       bpu_valid_i,
  input  logic                       ifu_accept_i,
  input  logic                       commit_valid_i,
  output logic                       bpu_ready_o,
  output logic                       ifu_valid_o,
  output logic                       enq_fire_o,
  output logic [$clog2(DEPTH)-1:0]   bpu_idx_o,
  output logic [$clog2(DEPTH)-1:0]   ifu_idx_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  logic [PTR_W-1:0] bpuPtr_q, bpuPtr_d;
  logic [PTR_W-1:0] ifuPtr_q, ifuPtr_d;
  logic [PTR_W-1:0] commPtr_q, commPtr_d;
  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] issuedCount;
  logic             full;
  logic             issueFire;
  logic             commitFire;

  assign count       = bpuPtr_q - commPtr_q;
  assign issuedCount = ifuPtr_q - commPtr_q;
  assign full        = (count == PTR_W'(DEPTH));

  assign bpu_ready_o = ~full & ~flush_i;
  assign ifu_valid_o = (ifuPtr_q != bpuPtr_q) & ~flush_i;
  assign enq_fire_o  = bpu_valid_i & bpu_ready_o;
  assign issueFire   = ifu_valid_o & ifu_accept_i;
  assign commitFire  = commit_valid_i & (commPtr_q != ifuPtr_q) & ~flush_i;

  assign bpu_idx_o = bpuPtr_q[IDX_W-1:0];
  assign ifu_idx_o = ifuPtr_q[IDX_W-1:0];
  assign count_o   = count;

  // Next pointer values: flush empties the queue, otherwise each fire advances its own pointer.
  always_comb begin
    bpuPtr_d  = bpuPtr_q;
    ifuPtr_d  = ifuPtr_q;
    commPtr_d = commPtr_q;
    if (flush_i) begin
      bpuPtr_d  = '0;
      ifuPtr_d  = '0;
      commPtr_d = '0;
    end else begin
      if (enq_fire_o) bpuPtr_d  = bpuPtr_q + 1'b1;
      if (issueFire)  ifuPtr_d  = ifuPtr_q + 1'b1;
      if (commitFire) commPtr_d = commPtr_q + 1'b1;
    end
  end

  // Pointer registers, cleared asynchronously so the queue is empty out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpuPtr_q  <= '0;
      ifuPtr_q  <= '0;
      commPtr_q <= '0;
    end else begin
      bpuPtr_q  <= bpuPtr_d;
      ifuPtr_q  <= ifuPtr_d;
      commPtr_q <= commPtr_d;
    end
  end

  aCommitIssued: assert property (@(posedge clk) disable iff (!rst_n)
    (commit_valid_i && !flush_i) |-> (commPtr_q != ifuPtr_q));

  aCountBound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= PTR_W'(DEPTH));

  aIfuBehindBpu: assert property (@(posedge clk) disable iff (!rst_n)
    issuedCount <= count);

endmodule

// File: rtl/fetch_target_queue.sv
// Fetch target queue: circular buffer of fetch blocks between the branch
// predictor and the IFU, holding issued blocks until backend commit.
module fetch_target_queue #(
  parameter int DEPTH           = fetch_target_queue_pkg::FTQ_DEPTH,
  parameter int FETCH_WIDTH     = fetch_target_queue_pkg::FTQ_FETCH_WIDTH,
  parameter int ADDR_WIDTH      = fetch_target_queue_pkg::FTQ_ADDR_WIDTH,
  parameter int CACHELINE_BYTES = fetch_target_queue_pkg::CACHELINE_BYTES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           bpu_valid_i,
  input  logic [ADDR_WIDTH-1:0]          bpu_start_pc_i,
  input  logic [$clog2(FETCH_WIDTH):0]   bpu_length_i,
  output logic                           bpu_ready_o,
  output logic                           ifu_valid_o,
  output logic [ADDR_WIDTH-1:0]          ifu_start_pc_o,
  output logic [$clog2(FETCH_WIDTH):0]   ifu_length_o,
  output logic                           ifu_is_cross_cacheline_o,
  output logic [$clog2(DEPTH)-1:0]       ifu_id_o,
  input  logic                           ifu_accept_i,
  input  logic                           commit_valid_i,
  input  logic                           flush_i,
  output logic [$clog2(DEPTH):0]         count_o
);

  import fetch_target_queue_pkg::*;

  localparam int LEN_W = $clog2(FETCH_WIDTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(CACHELINE_BYTES) - 2;
  localparam int SUM_W = $clog2(FETCH_WIDTH) + 2;

  ftq_entry_t  entries_q [DEPTH];
  ftq_to_ifu_t ifuOut;

  logic             enqFire;
  logic [IDX_W-1:0] bpuIdx;
  logic [IDX_W-1:0] ifuIdx;
  logic [SUM_W-1:0] crossSum;
  logic             enqCross;

  ftq_ptr_ctrl #(
    .DEPTH(DEPTH)
  ) u_ptr_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .bpu_valid_i    (bpu_valid_i),
    .ifu_accept_i   (ifu_accept_i),
    .commit_valid_i (commit_valid_i),
    .bpu_ready_o    (bpu_ready_o),
    .ifu_valid_o    (ifu_valid_o),
    .enq_fire_o     (enqFire),
    .bpu_idx_o      (bpuIdx),
    .ifu_idx_o      (ifuIdx),
    .count_o        (count_o)
  );

  // Word offset within the cacheline plus instruction count; beyond one line's worth means a second line is touched.
  assign crossSum = SUM_W'(bpu_start_pc_i[2 +: OFF_W]) + SUM_W'(bpu_length_i);
  assign enqCross = crossSum > SUM_W'(FETCH_WIDTH);

  // Entry storage is never reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (enqFire) begin
      entries_q[bpuIdx] <= '{start_pc:           bpu_start_pc_i,
                             length:             bpu_length_i,
                             is_cross_cacheline: enqCross};
    end
  end

  // Present the block at the issue pointer, forcing the whole bundle to zero when nothing is valid.
  always_comb begin
    ifuOut = '0;
    if (ifu_valid_o) begin
      ifuOut.valid              = 1'b1;
      ifuOut.start_pc           = entries_q[ifuIdx].start_pc;
      ifuOut.length             = entries_q[ifuIdx].length;
      ifuOut.is_cross_cacheline = entries_q[ifuIdx].is_cross_cacheline;
      ifuOut.id                 = ifuIdx;
    end
  end

  assign ifu_start_pc_o           = ifuOut.start_pc;
  assign ifu_length_o             = ifuOut.length;
  assign ifu_is_cross_cacheline_o = ifuOut.is_cross_cacheline;
  assign ifu_id_o                 = ifuOut.id;

  aLengthRange: assert property (@(posedge clk) disable iff (!rst_n)
    (bpu_valid_i && bpu_ready_o) |-> (bpu_length_i != '0 && bpu_length_i <= LEN_W'(FETCH_WIDTH)));

endmodule
